fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupling buffer between instruction fetch and decode. Holds up to DEPTH fetched {pc, instr} pairs in order. Back-pressure toward fetch goes through enq_ready, which stalls the PC register. A control-flow redirect (taken branch, jal, jalr) flushes the queue so that wrong-path instructions never reach decode.

## Interface
- ADDRESS_WIDTH, 32, width of pc and instruction words
- DEPTH, 4, entry count; power of two, at least 2
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- enq_valid  input  1  fetch presents a valid {enq_pc, enq_instr}
- enq_pc  input  ADDRESS_WIDTH  pc of the fetched instruction
- enq_instr  input  ADDRESS_WIDTH  fetched instruction word
- enq_ready  output  1  queue accepts an entry this cycle
- deq_valid  output  1  head entry valid toward decode
- deq_pc  output  ADDRESS_WIDTH  pc of the head entry
- deq_instr  output  ADDRESS_WIDTH  instruction word of the head entry
- deq_ready  input  1  decode consumes the head this cycle
- flush  input  1  redirect; discard all entries
- count  output  $clog2(DEPTH)+1  current occupancy

## Operation
- Storage: circular buffer of DEPTH entries, each 2×ADDRESS_WIDTH bits. Entries are not reset.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH. Occupancy is kept in a count register (0..DEPTH).
- enq fire = enq_valid & enq_ready
  - Writes the entry at wr_ptr.
  - Advances wr_ptr.
- deq fire = deq_valid & deq_ready
  - Advances rd_ptr.
- count update:
  - +1 on enq fire only.
  - −1 on deq fire only.
  - Unchanged when both fire, or when neither fires.
- enq_ready = !rst & !flush & (count != DEPTH).
  - enq_ready does not depend on deq_ready. A full queue refuses enqueue even when a dequeue happens in the same cycle.
- deq_valid = !flush & (count != 0).
- deq_pc and deq_instr:
  - Show the entry at rd_ptr when deq_valid = 1.
  - Drive all-zero when deq_valid = 0.
- There is no bypass path. An entry written at edge N is visible at the output only after that edge.
- flush = 1 (priority over everything except rst):
  - At the next edge, count, wr_ptr and rd_ptr all go to 0.
  - No enqueue and no dequeue takes effect in that cycle.
- The enqueue/dequeue handshakes are valid/ready style:
  - The producer holds enq_pc and enq_instr stable while enq_valid = 1 and enq_ready = 0.
  - Data is taken only on fire.
- Order is strict FIFO. Every accepted entry comes out exactly once, unless a flush discards it first.

## Timing
- Reset, applied on the edge where rst = 1: count = 0, wr_ptr = 0, rd_ptr = 0.
- Outputs while rst = 1 and in the first cycle after it:
  - deq_valid = 0.
  - deq_pc = 0 and deq_instr = 0.
  - count = 0.
  - enq_ready = 0 while rst is high, and 1 in the first cycle after rst falls.
- Latency: enq fire at edge N gives deq_valid = 1 in cycle N+1 (one cycle minimum).
- Throughput: one enqueue and one dequeue per cycle.
- Steady-state streaming from empty: one instruction per cycle, one cycle of latency.
- Full (count = DEPTH): enq_ready = 0. It returns to 1 in the cycle after the first deq fire.
- Empty: deq_valid = 0, and deq_ready is ignored.
- Pointer wrap: after index DEPTH−1 a pointer returns to 0, with no gap or bubble.
- flush asserted in cycle N:
  - deq_valid = 0 and enq_ready = 0 combinationally during cycle N.
  - The queue is empty from cycle N+1.
  - The first post-redirect instruction can be enqueued in cycle N+1.
- A flush held for several cycles keeps the queue empty and blocks enqueue for its whole duration.
- rst mid-operation (non-empty queue) takes effect like flush at the next edge, and also drives enq_ready = 0 during reset.

## Test plan
- Reset and idle: reset, then enq_valid = 0 for 3 cycles → deq_valid = 0, count = 0, enq_ready = 1, deq_pc = 0.
- Fill to full (DEPTH = 4): enqueue pc 0x00, 0x04, 0x08, 0x0C with deq_ready = 0 → count = 4 and enq_ready = 0. Then offer pc 0x10 → it is not accepted and count stays 4.
- Drain in order from the full state: set deq_ready = 1 → deq_pc reads 0x00, 0x04, 0x08, 0x0C on consecutive cycles; then deq_valid = 0 and count = 0.
- Streaming with wrap-around: enqueue and dequeue simultaneously every cycle for 10 instructions (pc 0x00 to 0x24) → each pc appears exactly once, in order, one cycle after its enqueue; count stays at 1 after the first cycle; pointers wrap twice without error.
- Flush mid-operation: with 3 entries held, assert flush together with enq_valid (pc 0x40) and deq_ready:
  - → In that cycle, deq_valid = 0 and enq_ready = 0.
  - → In the next cycle, count = 0.
  - → Enqueueing pc 0x80 then produces deq_pc = 0x80 one cycle later, and no stale entry appears.
- Back-pressure stability: toggle deq_ready pseudo-randomly for 200 cycles while enq_valid is random → the dequeued sequence equals the enqueued sequence, and count never exceeds 4 or goes below 0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue handshake bundle: enqueue side from fetch, dequeue side toward decode.
// master = fetch/decode pipeline stages, slave = the queue itself.
interface fetch_queue_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH         = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                     enq_valid;
  logic [ADDRESS_WIDTH-1:0] enq_pc;
  logic [ADDRESS_WIDTH-1:0] enq_instr;
  logic                     enq_ready;
  logic                     deq_valid;
  logic [ADDRESS_WIDTH-1:0] deq_pc;
  logic [ADDRESS_WIDTH-1:0] deq_instr;
  logic                     deq_ready;
  logic                     flush;
  logic [CNT_W-1:0]         count;

  modport master (
    output enq_valid, enq_pc, enq_instr, deq_ready, flush,
    input  enq_ready, deq_valid, deq_pc, deq_instr, count
  );

  modport slave (
    input  enq_valid, enq_pc, enq_instr, deq_ready, flush,
    output enq_ready, deq_valid, deq_pc, deq_instr, count
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order {pc, instr} buffer between fetch and decode; one-cycle enq-to-deq latency, no bypass.
// Full queue drops enq_ready regardless of deq_ready; flush/rst empty it at the next edge.
module fetch_queue #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH         = 4
) (
  input logic         clk,
  input logic         rst,
  fetch_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH-1:0] instr;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic   full, empty;
  logic   enq_ready, deq_valid;
  logic   enq_fire, deq_fire;
  entry_t head, enq_entry;

  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    empty     = (count_q == '0);
    // Gating deq_valid with rst keeps decode from seeing stale entries during a mid-run reset.
    enq_ready = !rst && !bus.flush && !full;
    deq_valid = !rst && !bus.flush && !empty;
    enq_fire  = bus.enq_valid && enq_ready;
    deq_fire  = deq_valid && bus.deq_ready;
    head      = mem_q[rd_ptr_q];
    enq_entry = '{pc: bus.enq_pc, instr: bus.enq_instr};
  end

  assign bus.enq_ready = enq_ready;
  assign bus.deq_valid = deq_valid;
  assign bus.deq_pc    = deq_valid ? head.pc    : '0;
  assign bus.deq_instr = deq_valid ? head.instr : '0;
  assign bus.count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) begin
        mem_d[wr_ptr_q] = enq_entry;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  fetch_queue_if #(.ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] pc;
    logic [AW-1:0] instr;
  } item_t;

  item_t model_q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    exp_er, exp_dv;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle's inputs and compare every output with the reference model.
  task automatic drive(input bit r, input bit f, input bit ev, input logic [AW-1:0] pc,
                       input logic [AW-1:0] instr, input bit dr);
    rst           = r;
    bus.flush     = f;
    bus.enq_valid = ev;
    bus.enq_pc    = pc;
    bus.enq_instr = instr;
    bus.deq_ready = dr;
    #1;
    exp_er = !r && !f && (model_q.size() < DEPTH);
    exp_dv = !r && !f && (model_q.size() != 0);
    check_eq("enq_ready", bus.enq_ready, exp_er);
    check_eq("deq_valid", bus.deq_valid, exp_dv);
    check_eq("deq_pc",    bus.deq_pc,    exp_dv ? model_q[0].pc    : '0);
    check_eq("deq_instr", bus.deq_instr, exp_dv ? model_q[0].instr : '0);
    check_eq("count",     bus.count,     model_q.size());
  endtask

  task automatic advance();
    if (rst || bus.flush) begin
      model_q.delete();
    end else begin
      if (exp_dv && bus.deq_ready) void'(model_q.pop_front());
      if (exp_er && bus.enq_valid) model_q.push_back('{pc: bus.enq_pc, instr: bus.enq_instr});
    end
    @(negedge clk);
  endtask

  initial begin
    bit            pending;
    logic [AW-1:0] ppc, pinstr, next_pc;
    bit            r, f, dr, fired;

    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.enq_valid = 1'b0;
    bus.enq_pc    = '0;
    bus.enq_instr = '0;
    bus.deq_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset held, then idle
    drive(1, 0, 0, 0, 0, 0);
    check_eq("rst_enq_ready", bus.enq_ready, 0);
    check_eq("rst_deq_valid", bus.deq_valid, 0);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      check_eq("idle_enq_ready", bus.enq_ready, 1);
      check_eq("idle_count",     bus.count,     0);
      check_eq("idle_deq_pc",    bus.deq_pc,    0);
      advance();
    end

    // Fill to full, then offer one more
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, AW'(i * 4), $urandom, 0);
      advance();
    end
    drive(0, 0, 1, 32'h10, $urandom, 0);
    check_eq("full_count",     bus.count,     4);
    check_eq("full_enq_ready", bus.enq_ready, 0);
    advance();

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 1);
      check_eq("drain_pc", bus.deq_pc, 64'(i * 4));
      if (i == 0) check_eq("drain_start_count", bus.count, 4);
      advance();
    end
    drive(0, 0, 0, 0, 0, 1);
    check_eq("drained_valid", bus.deq_valid, 0);
    check_eq("drained_count", bus.count,     0);
    advance();

    // Streaming with pointer wrap
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, AW'(i * 4), $urandom, 1);
      if (i > 0) begin
        check_eq("stream_count", bus.count,  1);
        check_eq("stream_pc",    bus.deq_pc, 64'((i - 1) * 4));
      end
      advance();
    end
    drive(0, 0, 0, 0, 0, 1);
    check_eq("stream_last_pc", bus.deq_pc, 32'h24);
    advance();
    drive(0, 0, 0, 0, 0, 1);
    check_eq("stream_empty", bus.deq_valid, 0);
    advance();

    // Flush with three entries held
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, AW'(32'h100 + i * 4), $urandom, 0);
      advance();
    end
    drive(0, 1, 1, 32'h40, $urandom, 1);
    check_eq("flush_deq_valid", bus.deq_valid, 0);
    check_eq("flush_enq_ready", bus.enq_ready, 0);
    advance();
    drive(0, 0, 1, 32'h80, 32'h1234_5678, 0);
    check_eq("post_flush_count", bus.count,     0);
    check_eq("post_flush_ready", bus.enq_ready, 1);
    advance();
    drive(0, 0, 0, 0, 0, 1);
    check_eq("redirect_pc",    bus.deq_pc,    32'h80);
    check_eq("redirect_instr", bus.deq_instr, 32'h1234_5678);
    check_eq("redirect_count", bus.count,     1);
    advance();
    drive(0, 0, 0, 0, 0, 1);
    check_eq("no_stale", bus.deq_valid, 0);
    advance();

    // Random back-pressure with occasional redirects and resets
    pending = 1'b0;
    ppc     = '0;
    pinstr  = '0;
    next_pc = 32'h1000;
    for (int c = 0; c < 200; c++) begin
      r  = ($urandom % 50) == 0;
      f  = ($urandom % 25) == 0;
      dr = $urandom % 2;
      if (!pending && ($urandom % 3) != 0) begin
        pending = 1'b1;
        ppc     = next_pc;
        pinstr  = $urandom;
        next_pc = next_pc + 4;
      end
      drive(r, f, pending, ppc, pinstr, dr);
      check_eq("count_le_depth", bus.count <= DEPTH, 1);
      fired = exp_er && pending;
      advance();
      if (fired || r || f) pending = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
